// File: rtl/pmem_pkg.sv
// Shared types and default widths for the streamed-load program memory.
package pmem_pkg;

  localparam int PMEM_DATA_W = 12;
  localparam int PMEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pmem_array.sv
// Program storage: one synchronous write port and one registered read port.
// A disabled read returns zero data with rvalid low on the following cycle.
module pmem_array #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] rdata_d, rdata_q;
  logic             rvalid_d, rvalid_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d  = '0;
    rvalid_d = re;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/pmem_loader.sv
// Program memory with an auto-incrementing streamed load port and a
// load-session FSM. Define PMEM_PARITY_EN to store and check a parity bit.
module pmem_loader
  import pmem_pkg::*;
#(
  parameter int DATA_W = PMEM_DATA_W,
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_Addr,
  output logic [DATA_W-1:0] o_ReadInstr,
  output logic              o_rvalid,
  input  logic              i_ld_start,
  input  logic [ADDR_W-1:0] i_ld_base,
  input  logic [ADDR_W:0]   i_ld_count,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_busy,
  output logic              o_ld_done,
  output logic              o_ld_wrap
`ifdef PMEM_PARITY_EN
  ,
  input  logic              i_par_inj,
  output logic              o_par_err
`endif
);

`ifdef PMEM_PARITY_EN
  localparam int STORE_W = DATA_W + 1;
`else
  localparam int STORE_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Handshake: a load word transfers on any rising edge where
  // i_ld_valid and o_ld_ready are both high; o_ld_ready never depends on
  // i_ld_valid, and the source may hold i_ld_valid low indefinitely.

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   ptr_d, ptr_q;
  logic [ADDR_W:0]     rem_d, rem_q;
  logic                wrap_d, wrap_q;
  logic                wr_en;
  logic                rd_en;
  logic [STORE_W-1:0]  wr_word;
  logic [STORE_W-1:0]  rd_word;
  logic                rd_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ld_start) begin
          if (i_ld_count == '0) begin
            state_d = DONE;
          end else begin
            ptr_d   = i_ld_base;
            rem_d   = (i_ld_count > DEPTH_CNT) ? DEPTH_CNT : i_ld_count;
            wrap_d  = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (i_ld_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W+1)'(1);
          if (ptr_q == LAST_ADDR) begin
            wrap_d = 1'b1;
          end
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_ld_ready = (state_q == LOAD);
  assign o_ld_done  = (state_q == DONE);
  assign o_ld_wrap  = wrap_q;

  // Reads are blocked for the whole session, so no read/write collision.
  assign rd_en = i_en & ~o_busy;

`ifdef PMEM_PARITY_EN
  assign wr_word   = {(^i_ld_data) ^ i_par_inj, i_ld_data};
  assign o_par_err = ^rd_word;
`else
  assign wr_word   = i_ld_data;
`endif

  pmem_array #(
    .WIDTH  (STORE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (i_clk),
    .rst    (i_rst),
    .we     (wr_en),
    .waddr  (ptr_q),
    .wdata  (wr_word),
    .re     (rd_en),
    .raddr  (i_Addr),
    .rdata  (rd_word),
    .rvalid (rd_valid)
  );

  assign o_ReadInstr = rd_word[DATA_W-1:0];
  assign o_rvalid    = rd_valid;

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: table-driven load sessions, hand-written
// corner sequences and randomized sessions against an array reference model.
module tb_pmem_loader;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_en;
  logic [ADDR_W-1:0] i_Addr;
  logic [DATA_W-1:0] o_ReadInstr;
  logic              o_rvalid;
  logic              i_ld_start;
  logic [ADDR_W-1:0] i_ld_base;
  logic [ADDR_W:0]   i_ld_count;
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic [DATA_W-1:0] i_ld_data;
  logic              o_busy;
  logic              o_ld_done;
  logic              o_ld_wrap;
`ifdef PMEM_PARITY_EN
  logic              i_par_inj;
  logic              o_par_err;
  bit                ref_bad [DEPTH];
`endif

  pmem_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (i_en),
    .i_Addr      (i_Addr),
    .o_ReadInstr (o_ReadInstr),
    .o_rvalid    (o_rvalid),
    .i_ld_start  (i_ld_start),
    .i_ld_base   (i_ld_base),
    .i_ld_count  (i_ld_count),
    .i_ld_valid  (i_ld_valid),
    .o_ld_ready  (o_ld_ready),
    .i_ld_data   (i_ld_data),
    .o_busy      (o_busy),
    .o_ld_done   (o_ld_done),
    .o_ld_wrap   (o_ld_wrap)
`ifdef PMEM_PARITY_EN
    ,
    .i_par_inj   (i_par_inj),
    .o_par_err   (o_par_err)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                known   [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                n_checks = 0;
  int                n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   cnt;
    int                mode;        // 0 valid held, 1 valid toggling, 2 random
    int                exp_cycles;  // LOAD cycles
    bit                exp_wrap;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_cnt(input logic [ADDR_W:0] cnt);
    return (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
  endfunction

  // driver tasks: every task starts and ends right after a falling edge
  task automatic read_check(input logic [ADDR_W-1:0] addr, input string name);
    i_en   = 1'b1;
    i_Addr = addr;
    if (known[addr]) exp_q.push_back(ref_mem[addr]);
    @(negedge clk);
    i_en = 1'b0;
    check({name, "_rvalid"}, 32'(o_rvalid), 32'd1);
    if (known[addr]) check({name, "_data"}, 32'(o_ReadInstr), 32'(exp_q.pop_front()));
`ifdef PMEM_PARITY_EN
    if (known[addr]) check({name, "_parerr"}, 32'(o_par_err), 32'(ref_bad[addr]));
`endif
  endtask

  task automatic feed(input logic [ADDR_W-1:0] base, input int n, input int mode,
                      output int cyc);
    int acc = 0;
    bit bad = 1'b0;
    bit v;
    logic [DATA_W-1:0] w;
    cyc = 0;
    while (acc < n && cyc < 4000) begin
      if (o_ld_ready !== 1'b1 || o_ld_done !== 1'b0 || o_busy !== 1'b1) bad = 1'b1;
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      w          = DATA_W'($urandom);
      i_ld_valid = v;
      i_ld_data  = w;
      @(negedge clk);
      if (v) begin
        ref_mem[ADDR_W'(int'(base) + acc)] = w;
        known[ADDR_W'(int'(base) + acc)]   = 1'b1;
`ifdef PMEM_PARITY_EN
        ref_bad[ADDR_W'(int'(base) + acc)] = 1'b0;
`endif
        acc++;
      end
    end
    i_ld_valid = 1'b0;
    check("load_handshake", 32'(bad), 32'd0);
    check("done_pulse", 32'(o_ld_done), 32'd1);
    check("done_ready_low", 32'(o_ld_ready), 32'd0);
    check("done_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("after_done_pulse", 32'(o_ld_done), 32'd0);
    check("after_done_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic run_session(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                             input int mode, output int cyc);
    i_ld_start = 1'b1;
    i_ld_base  = base;
    i_ld_count = cnt;
    @(negedge clk);
    i_ld_start = 1'b0;
    cyc = 0;
    if (cnt == '0) begin
      check("cnt0_done", 32'(o_ld_done), 32'd1);
      check("cnt0_busy", 32'(o_busy), 32'd1);
      check("cnt0_ready", 32'(o_ld_ready), 32'd0);
      @(negedge clk);
      check("cnt0_done_end", 32'(o_ld_done), 32'd0);
      check("cnt0_busy_end", 32'(o_busy), 32'd0);
    end else begin
      feed(base, clamp_cnt(cnt), mode, cyc);
    end
  endtask

  initial begin
    int cyc;
    int n;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0]   c;
    logic [DATA_W-1:0] old62;

    vecs[0] = '{8'h10, 9'd3,     0, 3,   1'b0};
    vecs[1] = '{8'hFE, 9'd4,     1, 7,   1'b1};
    vecs[2] = '{8'h40, 9'd1,     0, 1,   1'b0};
    vecs[3] = '{8'h00, 9'h100,   0, 256, 1'b1};
    vecs[4] = '{8'hF0, 9'h150,   0, 256, 1'b1};
    vecs[5] = '{8'h20, 9'd2,     1, 3,   1'b0};

    rst = 1'b1; i_en = 1'b1; i_Addr = '0; i_ld_start = 1'b0; i_ld_base = '0;
    i_ld_count = '0; i_ld_valid = 1'b0; i_ld_data = '0;
`ifdef PMEM_PARITY_EN
    i_par_inj = 1'b0;
`endif

    // reset: every output low even with a read requested
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_data", 32'(o_ReadInstr), 32'd0);
    check("rst_ready", 32'(o_ld_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_ld_done), 32'd0);
    check("rst_wrap", 32'(o_ld_wrap), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_read_rvalid", 32'(o_rvalid), 32'd1);
    check("first_read_busy", 32'(o_busy), 32'd0);
    i_en = 1'b0;
    @(negedge clk);
    check("idle_rvalid", 32'(o_rvalid), 32'd0);
    check("idle_data", 32'(o_ReadInstr), 32'd0);

    // table-driven sessions
    for (int v = 0; v < 6; v++) begin
      run_session(vecs[v].base, vecs[v].cnt, vecs[v].mode, cyc);
      check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      check($sformatf("vec%0d_wrap", v), 32'(o_ld_wrap), 32'(vecs[v].exp_wrap));
      n = clamp_cnt(vecs[v].cnt);
      for (int i = 0; i < n && i < 4; i++)
        read_check(ADDR_W'(int'(vecs[v].base) + i), $sformatf("vec%0d_rd%0d", v, i));
      read_check(ADDR_W'(int'(vecs[v].base) + n - 1), $sformatf("vec%0d_rdlast", v));
    end

    // start while busy is ignored; reads blocked during the session
    i_ld_start = 1'b1; i_ld_base = 8'h30; i_ld_count = 9'd4;
    @(negedge clk);
    i_ld_start = 1'b1; i_ld_base = 8'h00; i_ld_count = 9'd1;
    i_en = 1'b1; i_Addr = 8'h10;
    @(negedge clk);
    check("busy_rd_rvalid", 32'(o_rvalid), 32'd0);
    check("busy_rd_data", 32'(o_ReadInstr), 32'd0);
    check("restart_ignored_ready", 32'(o_ld_ready), 32'd1);
    i_ld_start = 1'b0; i_en = 1'b0;
    feed(8'h30, 4, 0, cyc);
    for (int i = 0; i < 4; i++) read_check(ADDR_W'(8'h30 + i), $sformatf("restart_rd%0d", i));

    // a read issued with the start still completes
    i_ld_start = 1'b1; i_ld_base = 8'h50; i_ld_count = 9'd2;
    i_en = 1'b1; i_Addr = 8'h10;
    exp_q.push_back(ref_mem[8'h10]);
    @(negedge clk);
    i_ld_start = 1'b0; i_en = 1'b0;
    check("start_rd_rvalid", 32'(o_rvalid), 32'd1);
    check("start_rd_data", 32'(o_ReadInstr), 32'(exp_q.pop_front()));
    feed(8'h50, 2, 0, cyc);

    // count 0: immediate done, memory untouched
    run_session(8'h10, 9'd0, 0, cyc);
    read_check(8'h10, "cnt0_mem");

    // reset after 2 of 5 writes
    run_session(8'h60, 9'd3, 0, cyc);
    old62 = ref_mem[8'h62];
    i_ld_start = 1'b1; i_ld_base = 8'h60; i_ld_count = 9'd5;
    @(negedge clk);
    i_ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = DATA_W'($urandom);
      ref_mem[ADDR_W'(8'h60 + i)] = i_ld_data;
      @(negedge clk);
    end
    i_ld_valid = 1'b0;
    check("abort_pre_done", 32'(o_ld_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_ld_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_done_after", 32'(o_ld_done), 32'd0);
    read_check(8'h60, "abort_rd60");
    read_check(8'h61, "abort_rd61");
    read_check(8'h62, "abort_rd62");
    check("abort_old62_kept", 32'(ref_mem[8'h62]), 32'(old62));

`ifdef PMEM_PARITY_EN
    i_ld_start = 1'b1; i_ld_base = 8'h20; i_ld_count = 9'd2;
    @(negedge clk);
    i_ld_start = 1'b0;
    i_ld_valid = 1'b1; i_ld_data = 12'h5A5; i_par_inj = 1'b1;
    @(negedge clk);
    i_par_inj = 1'b0;
    @(negedge clk);
    i_ld_valid = 1'b0;
    ref_mem[8'h20] = 12'h5A5; ref_bad[8'h20] = 1'b1;
    ref_mem[8'h21] = 12'h5A5; ref_bad[8'h21] = 1'b0;
    check("par_done", 32'(o_ld_done), 32'd1);
    @(negedge clk);
    read_check(8'h20, "par_inj");
    read_check(8'h21, "par_ok");
    @(negedge clk);
    check("par_idle_err", 32'(o_par_err), 32'd0);
`endif

    // randomized sessions against the model
    for (int s = 0; s < 8; s++) begin
      b = ADDR_W'($urandom_range(0, 255));
      c = (s == 3) ? 9'd300 : 9'($urandom_range(1, 24));
      n = clamp_cnt(c);
      run_session(b, c, 2, cyc);
      check($sformatf("rnd%0d_wrap", s), 32'(o_ld_wrap), 32'((int'(b) + n) >= DEPTH));
      for (int i = 0; i < n && i < 24; i++)
        read_check(ADDR_W'(int'(b) + i), $sformatf("rnd%0d_rd%0d", s, i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
